// File: rtl/can_crc_checker_pkg.sv
// can_pkg: shared CAN CRC-15 constants and checker state type
package can_pkg;
  localparam int CRC_W = 15;
  localparam int LEN_W = 7;
  localparam logic [CRC_W-1:0] CAN_CRC15_POLY = 15'h4599;
  localparam logic [CRC_W-1:0] CAN_CRC15_INIT = 15'h0000;
  localparam int MAX_COVER_LEN = 103;
  typedef enum logic [1:0] {IDLE, COVER, CRC_FIELD, DELIM} chk_state_t;
endpackage

// File: rtl/can_crc_checker_if.sv
// can_crc_checker_if: receive stream in, CRC check results out
interface can_crc_checker_if;
  import can_pkg::*;
  logic             frame_start;
  logic [LEN_W-1:0] cover_len;
  logic             bit_valid;
  logic             bit_in;
  logic             abort;
  logic             busy;
  logic [CRC_W-1:0] crc_calc;
  logic [CRC_W-1:0] crc_rx;
  logic             done;
  logic             crc_ok;
  logic             crc_err;
  logic             form_err;
  modport master (output frame_start, cover_len, bit_valid, bit_in, abort,
                  input busy, crc_calc, crc_rx, done, crc_ok, crc_err, form_err);
  modport slave (input frame_start, cover_len, bit_valid, bit_in, abort,
                 output busy, crc_calc, crc_rx, done, crc_ok, crc_err, form_err);
endinterface

// File: rtl/can_crc_checker_step.sv
// can_crc15_step: one-bit CAN CRC-15 LFSR update
module can_crc15_step
  import can_pkg::*;
(
  input  logic [CRC_W-1:0] crc_in,
  input  logic             bit_in,
  output logic [CRC_W-1:0] crc_out
);
  logic nxt;
  assign nxt = bit_in ^ crc_in[CRC_W-1];
  assign crc_out = {crc_in[CRC_W-2:0], 1'b0} ^ (nxt ? CAN_CRC15_POLY : '0);
endmodule

// File: rtl/can_crc_checker.sv
// can_crc_checker: checks the CRC-15 and delimiter of a destuffed CAN receive stream
module can_crc_checker
  import can_pkg::*;
(
  input logic              clk,
  input logic              rst_n,
  can_crc_checker_if.slave bus
);
  chk_state_t state, state_nxt;
  logic [CRC_W-1:0] lfsr, lfsr_nxt, lfsr_step, rx, rx_nxt;
  logic [LEN_W-1:0] cnt, cnt_nxt;
  logic done, done_nxt, ok, ok_nxt, err, err_nxt, form, form_nxt;
  can_crc15_step u_step (.crc_in(lfsr), .bit_in(bus.bit_in), .crc_out(lfsr_step));
  // state, CRC and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      lfsr  <= CAN_CRC15_INIT;
      rx    <= '0;
      cnt   <= '0;
      done  <= 1'b0;
      ok    <= 1'b0;
      err   <= 1'b0;
      form  <= 1'b0;
    end else begin
      state <= state_nxt;
      lfsr  <= lfsr_nxt;
      rx    <= rx_nxt;
      cnt   <= cnt_nxt;
      done  <= done_nxt;
      ok    <= ok_nxt;
      err   <= err_nxt;
      form  <= form_nxt;
    end
  end
  // abort beats frame_start, frame_start beats bit_valid; the counter tracks bits left in the field
  always_comb begin
    state_nxt = state;
    lfsr_nxt  = lfsr;
    rx_nxt    = rx;
    cnt_nxt   = cnt;
    done_nxt  = 1'b0;
    ok_nxt    = ok;
    err_nxt   = err;
    form_nxt  = form;
    if (bus.abort) begin
      state_nxt = IDLE;
    end else if (bus.frame_start) begin
      state_nxt = (bus.cover_len == '0) ? CRC_FIELD : COVER;
      cnt_nxt   = (bus.cover_len == '0) ? LEN_W'(CRC_W) : bus.cover_len;
      lfsr_nxt  = CAN_CRC15_INIT;
      rx_nxt    = '0;
      ok_nxt    = 1'b0;
      err_nxt   = 1'b0;
      form_nxt  = 1'b0;
    end else if (bus.bit_valid) begin
      case (state)
        COVER: begin
          lfsr_nxt  = lfsr_step;
          cnt_nxt   = (cnt == LEN_W'(1)) ? LEN_W'(CRC_W) : cnt - LEN_W'(1);
          state_nxt = (cnt == LEN_W'(1)) ? CRC_FIELD : COVER;
        end
        CRC_FIELD: begin
          rx_nxt    = {rx[CRC_W-2:0], bus.bit_in};
          cnt_nxt   = cnt - LEN_W'(1);
          state_nxt = (cnt == LEN_W'(1)) ? DELIM : CRC_FIELD;
        end
        DELIM: begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
          ok_nxt    = (rx == lfsr);
          err_nxt   = (rx != lfsr);
          form_nxt  = ~bus.bit_in;
        end
        default: state_nxt = state;
      endcase
    end
  end
  assign bus.busy     = (state != IDLE);
  assign bus.crc_calc = lfsr;
  assign bus.crc_rx   = rx;
  assign bus.done     = done;
  assign bus.crc_ok   = ok;
  assign bus.crc_err  = err;
  assign bus.form_err = form;
endmodule
